// File: rtl/countdown_timer_pkg.sv
// Shared constants for the countdown timer: default sizing and FSM state codes.
package timer_pkg;

    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_PRESC_W   = 25;
    localparam int unsigned DEF_PRESC_DIV = 2**24;

    localparam int unsigned STATE_W = 2;

    typedef logic [STATE_W-1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle between a timer and the agent that loads, starts and pauses it.
interface countdown_timer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             pause;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             running;
    logic             tc_pulse;
    logic             done;

    modport master (
        output load_valid, load_val, start, pause, auto_reload,
        input  load_ready, count, running, tc_pulse, done
    );

    modport slave (
        input  load_valid, load_val, start, pause, auto_reload,
        output load_ready, count, running, tc_pulse, done
    );
endinterface

// File: rtl/countdown_timer_tick_prescaler.sv
// One-cycle tick enable every PRESC_DIV enabled cycles; replaces a divided clock.
module tick_prescaler #(
    parameter int unsigned PRESC_W   = 25,
    parameter int unsigned PRESC_DIV = 2**24
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam logic [PRESC_W-1:0] LAST = PRESC_W'(PRESC_DIV - 1);

    logic [PRESC_W-1:0] presc_q;

    assign tick = en && (presc_q == LAST);

    // Phase counter: cleared on request, advances only while enabled, holds otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_q <= '0;
        end else if (clr) begin
            presc_q <= '0;
        end else if (en) begin
            presc_q <= tick ? '0 : presc_q + PRESC_W'(1);
        end
    end
endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with pause and auto-reload, stepped by a prescaler tick.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned PRESC_W   = DEF_PRESC_W,
    parameter int unsigned PRESC_DIV = DEF_PRESC_DIV
) (
    input  logic              clk,
    input  logic              rst,
    countdown_timer_if.slave  bus
);
    state_t           state_q, state_nxt;
    logic [WIDTH-1:0] count_q, count_nxt;
    logic [WIDTH-1:0] reload_q, reload_nxt;
    logic             tc_q, tc_nxt;
    logic             running_q, done_q;
    logic             load_ready_c;
    logic             load_acc_c;
    logic             presc_en_c;
    logic             presc_clr_c;
    logic             tick_c;

    assign load_ready_c = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign load_acc_c   = bus.load_valid && load_ready_c;
    assign presc_en_c   = (state_q == ST_RUN) && !bus.pause;
    assign presc_clr_c  = (state_q == ST_IDLE) || (state_q == ST_DONE);

    tick_prescaler #(
        .PRESC_W   (PRESC_W),
        .PRESC_DIV (PRESC_DIV)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .en   (presc_en_c),
        .clr  (presc_clr_c),
        .tick (tick_c)
    );

    // Next state, next count/reload and terminal-count pulse.
    always_comb begin
        state_nxt  = state_q;
        count_nxt  = count_q;
        reload_nxt = reload_q;
        tc_nxt     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_acc_c) begin
                    count_nxt  = bus.load_val;
                    reload_nxt = bus.load_val;
                end else if (bus.start) begin
                    if (count_q != '0) begin
                        state_nxt = ST_RUN;
                    end else begin
                        state_nxt = ST_DONE;
                        tc_nxt    = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (bus.pause) begin
                    state_nxt = ST_PAUSE;
                end else if (tick_c) begin
                    if (count_q > WIDTH'(1)) begin
                        count_nxt = count_q - WIDTH'(1);
                    end else begin
                        tc_nxt = 1'b1;
                        if (bus.auto_reload) begin
                            count_nxt = reload_q;
                        end else begin
                            count_nxt = '0;
                            state_nxt = ST_DONE;
                        end
                    end
                end
            end
            ST_PAUSE: begin
                if (!bus.pause) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                if (load_acc_c) begin
                    count_nxt  = bus.load_val;
                    reload_nxt = bus.load_val;
                    state_nxt  = ST_IDLE;
                end else if (bus.start) begin
                    count_nxt = reload_q;
                    if (reload_q != '0) begin
                        state_nxt = ST_RUN;
                    end else begin
                        tc_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            tc_q      <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            count_q   <= count_nxt;
            reload_q  <= reload_nxt;
            tc_q      <= tc_nxt;
            running_q <= (state_nxt == ST_RUN) || (state_nxt == ST_PAUSE);
            done_q    <= (state_nxt == ST_DONE);
        end
    end

    assign bus.load_ready = load_ready_c;
    assign bus.count      = count_q;
    assign bus.running    = running_q;
    assign bus.tc_pulse   = tc_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: directed scenarios followed by random traffic.
module tb_countdown_timer;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DIV   = 4;

    logic clk;
    logic rst;

    countdown_timer_if #(.WIDTH(WIDTH)) bus ();

    countdown_timer #(
        .WIDTH     (WIDTH),
        .PRESC_W   (25),
        .PRESC_DIV (DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [WIDTH-1:0] count;
        logic             running;
        logic             tc;
        logic             done;
        logic             ready;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: mode is one of "idle", "run", "paused", "finished";
    // elapsed counts unpaused RUN cycles since the last count step.
    string      m_mode    = "idle";
    int         m_count   = 0;
    int         m_reload  = 0;
    int         m_elapsed = 0;
    bit         m_tc      = 0;

    bit         d_rst, d_lv, d_start, d_pause, d_auto;
    int         d_val;

    task automatic model_step();
        m_tc = 0;
        if (!d_rst) begin
            m_mode = "idle"; m_count = 0; m_reload = 0; m_elapsed = 0;
            return;
        end
        if (m_mode == "idle") begin
            if (d_lv) begin
                m_count = d_val; m_reload = d_val;
            end else if (d_start) begin
                m_elapsed = 0;
                if (m_count != 0) m_mode = "run";
                else begin m_mode = "finished"; m_tc = 1; end
            end
        end else if (m_mode == "run") begin
            if (d_pause) m_mode = "paused";
            else begin
                m_elapsed++;
                if (m_elapsed == DIV) begin
                    m_elapsed = 0;
                    if (m_count > 1) m_count--;
                    else begin
                        m_tc = 1;
                        if (d_auto) m_count = m_reload;
                        else begin m_count = 0; m_mode = "finished"; end
                    end
                end
            end
        end else if (m_mode == "paused") begin
            if (!d_pause) m_mode = "run";
        end else begin
            if (d_lv) begin
                m_count = d_val; m_reload = d_val; m_mode = "idle";
            end else if (d_start) begin
                m_count = m_reload; m_elapsed = 0;
                if (m_reload != 0) m_mode = "run";
                else m_tc = 1;
            end
        end
    endtask

    // Drive one cycle of inputs and queue the response expected after the next edge.
    task automatic step(input bit r, input bit lv, input int val, input bit st,
                        input bit pa, input bit ar);
        exp_t e;
        @(negedge clk);
        d_rst = r; d_lv = lv; d_val = val; d_start = st; d_pause = pa; d_auto = ar;
        rst             = r;
        bus.load_valid  = lv;
        bus.load_val    = WIDTH'(val);
        bus.start       = st;
        bus.pause       = pa;
        bus.auto_reload = ar;
        model_step();
        e.count   = WIDTH'(m_count);
        e.running = (m_mode == "run") || (m_mode == "paused");
        e.tc      = m_tc;
        e.done    = (m_mode == "finished");
        e.ready   = (m_mode == "idle") || (m_mode == "finished");
        exp_q.push_back(e);
    endtask

    task automatic idle_n(input int n, input bit pa, input bit ar);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, pa, ar);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    // Monitor: after every edge with a pending expectation, compare the DUT outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("count",      int'(bus.count),      int'(e.count));
                chk("running",    int'(bus.running),    int'(e.running));
                chk("tc_pulse",   int'(bus.tc_pulse),   int'(e.tc));
                chk("done",       int'(bus.done),       int'(e.done));
                chk("load_ready", int'(bus.load_ready), int'(e.ready));
            end
        end
    end

    initial begin
        rst = 1'b0;
        bus.load_valid = 1'b0; bus.load_val = '0; bus.start = 1'b0;
        bus.pause = 1'b0; bus.auto_reload = 1'b0;

        // Reset for two cycles.
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Single-shot countdown from 3.
        step(1, 1, 3, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        idle_n(16, 0, 0);

        // Auto-reload from 2, then drop auto_reload.
        step(1, 1, 2, 0, 0, 1);
        step(1, 0, 0, 1, 0, 1);
        idle_n(26, 0, 1);
        idle_n(12, 0, 0);

        // Pause in the middle of the first step.
        step(1, 1, 5, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        idle_n(2, 0, 0);
        idle_n(5, 1, 0);
        idle_n(26, 0, 0);

        // Load and start ignored while running; load wins over start in IDLE.
        step(1, 1, 4, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        idle_n(2, 0, 0);
        step(1, 1, 'h55, 1, 0, 0);
        step(1, 1, 'h55, 0, 0, 0);
        idle_n(18, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 7, 1, 0, 0);
        idle_n(2, 0, 0);

        // Start with count=0 from IDLE, then restart from DONE with reload 0.
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        idle_n(2, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        idle_n(1, 0, 0);

        // Reset in the middle of a run.
        step(1, 1, 9, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        idle_n(6, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        idle_n(3, 0, 0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            bit r, lv, st, pa, ar;
            int v;
            r  = ($urandom_range(0, 299) != 0);
            lv = ($urandom_range(0, 9) == 0);
            st = ($urandom_range(0, 7) == 0);
            pa = ($urandom_range(0, 5) == 0);
            ar = ($urandom_range(0, 1) == 1);
            v  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
            step(r, lv, v, st, pa, ar);
        end

        @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
